// File: rtl/bios_shadow_loader_if.sv
// Wishbone master-side bus bundle for the shadow-BIOS loader.
// Signals:
//   dat  [15:0] write data            adr [18:0] word address [19:1]
//   we         write qualifier        tga         address tag (0 = memory)
//   sel  [1:0] byte selects           stb/cyc     strobe / cycle
//   ack        slave acknowledge
interface bios_shadow_loader_if;
   localparam int unsigned DAT_W = 16;
   localparam int unsigned ADR_W = 19;
   localparam int unsigned SEL_W = 2;

   logic [DAT_W-1:0] dat;
   logic [ADR_W-1:0] adr;
   logic             we;
   logic             tga;
   logic [SEL_W-1:0] sel;
   logic             stb;
   logic             cyc;
   logic             ack;

   modport master (
      output dat, adr, we, tga, sel, stb, cyc,
      input  ack
   );

   modport slave (
      input  dat, adr, we, tga, sel, stb, cyc,
      output ack
   );
endinterface

// File: rtl/bios_shadow_loader.sv
// Boot-time copier: pulses flash reset, waits out recovery, then reads the
// BIOS image word by word from parallel flash and writes each word into
// shadow RAM through a Wishbone master port. done_o stays high until reset.
// Ports:
//   wb_clk_i, wb_rst_n_i       clock, async active-low reset
//   flash_addr_[21:0]          flash word address (FLASH_BASE + idx)
//   flash_data_[15:0]          flash read data
//   flash_we_n_/oe_n_/ce_n_    flash strobes, active low (we_n tied high)
//   flash_rst_n_               flash reset, active low
//   wbm                        Wishbone master (write-only)
//   done_o                     copy complete, sticky
module bios_shadow_loader #(
   parameter logic [21:0] FLASH_BASE = 22'h000000,
   parameter logic [18:0] RAM_BASE   = 19'h78000,
   parameter int unsigned WORDS      = 32768,
   parameter int unsigned FLASH_WAIT = 8,
   parameter int unsigned RST_CYC    = 16
) (
   input  logic                        wb_clk_i,
   input  logic                        wb_rst_n_i,
   output logic [21:0]                 flash_addr_,
   input  logic [15:0]                 flash_data_,
   output logic                        flash_we_n_,
   output logic                        flash_oe_n_,
   output logic                        flash_ce_n_,
   output logic                        flash_rst_n_,
   bios_shadow_loader_if.master        wbm,
   output logic                        done_o
);
   localparam int unsigned FA_W  = 22;
   localparam int unsigned RA_W  = 19;
   localparam int unsigned D_W   = 16;
   localparam int unsigned IDX_W = 17;
   localparam int unsigned CNT_W = 8;
   localparam int unsigned SEL_W = 2;

   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WORDS - 1);
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(FLASH_WAIT - 1);
   localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYC - 1);

   typedef enum logic [2:0] {
      FRST   = 3'd0,
      FRECOV = 3'd1,
      FREAD  = 3'd2,
      WRITE  = 3'd3,
      DONE   = 3'd4
   } state_e;

   state_e            state_q,      state_d;
   logic [IDX_W-1:0]  idx_q,        idx_d;
   logic [CNT_W-1:0]  cnt_q,        cnt_d;
   logic              frst_n_q,     frst_n_d;
   logic              ce_n_q,       ce_n_d;
   logic [FA_W-1:0]   flash_addr_q, flash_addr_d;
   logic              stb_q,        stb_d;
   logic [SEL_W-1:0]  sel_q,        sel_d;
   logic [RA_W-1:0]   adr_q,        adr_d;
   logic [D_W-1:0]    dat_q,        dat_d;
   logic              done_q,       done_d;

   // Next-state and next-output logic
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      cnt_d        = cnt_q;
      frst_n_d     = frst_n_q;
      ce_n_d       = ce_n_q;
      flash_addr_d = flash_addr_q;
      stb_d        = stb_q;
      sel_d        = sel_q;
      adr_d        = adr_q;
      dat_d        = dat_q;
      done_d       = done_q;

      unique case (state_q)
         // Hold the flash in reset for RST_CYC clocks
         FRST: begin
            if (cnt_q == RST_LAST) begin
               cnt_d    = '0;
               frst_n_d = 1'b1;
               state_d  = FRECOV;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         // Post-reset recovery, flash deselected; CE/OE open for the first read
         FRECOV: begin
            if (cnt_q == RST_LAST) begin
               cnt_d   = '0;
               ce_n_d  = 1'b0;
               state_d = FREAD;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         // Access time elapses, then sample data and launch the bus write
         FREAD: begin
            if (cnt_q == WAIT_LAST) begin
               cnt_d   = '0;
               dat_d   = flash_data_;
               ce_n_d  = 1'b1;
               stb_d   = 1'b1;
               sel_d   = '1;
               state_d = WRITE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         // Address and data held until the slave acknowledges
         WRITE: begin
            if (wbm.ack) begin
               stb_d = 1'b0;
               sel_d = '0;
               if (idx_q == LAST_IDX) begin
                  done_d  = 1'b1;
                  state_d = DONE;
               end else begin
                  // Next read starts straight away; both addresses wrap naturally
                  idx_d        = idx_q + IDX_W'(1);
                  flash_addr_d = FLASH_BASE + FA_W'(idx_d);
                  adr_d        = RAM_BASE + RA_W'(idx_d);
                  ce_n_d       = 1'b0;
                  state_d      = FREAD;
               end
            end
         end

         DONE: begin
         end

         default: begin
            state_d = FRST;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         state_q      <= FRST;
         idx_q        <= '0;
         cnt_q        <= '0;
         frst_n_q     <= 1'b0;
         ce_n_q       <= 1'b1;
         flash_addr_q <= FLASH_BASE;
         stb_q        <= 1'b0;
         sel_q        <= '0;
         adr_q        <= RAM_BASE;
         dat_q        <= '0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         frst_n_q     <= frst_n_d;
         ce_n_q       <= ce_n_d;
         flash_addr_q <= flash_addr_d;
         stb_q        <= stb_d;
         sel_q        <= sel_d;
         adr_q        <= adr_d;
         dat_q        <= dat_d;
         done_q       <= done_d;
      end
   end

   // CE and OE always move together; the flash is never written
   assign flash_addr_  = flash_addr_q;
   assign flash_ce_n_  = ce_n_q;
   assign flash_oe_n_  = ce_n_q;
   assign flash_we_n_  = 1'b1;
   assign flash_rst_n_ = frst_n_q;

   // A single write burst drives cyc, stb and we together
   assign wbm.cyc = stb_q;
   assign wbm.stb = stb_q;
   assign wbm.we  = stb_q;
   assign wbm.sel = sel_q;
   assign wbm.adr = adr_q;
   assign wbm.dat = dat_q;
   assign wbm.tga = 1'b0;

   assign done_o = done_q;
endmodule

// File: tb/tb_bios_shadow_loader.sv
// Bench for bios_shadow_loader: three loaders with different address
// bases and image lengths, each against a registered-ack slave with random
// wait states and random stray acks, plus a flash model whose data is only
// valid after the access time has elapsed.
module tb_bios_shadow_loader;
   localparam int N    = 3;
   localparam int FW   = 2;
   localparam int RC   = 2;
   localparam int RMAX = 8;

   logic clk;
   logic rst_a, rst_bc, spur_en;
   logic rst_n [N];

   logic [21:0] faddr [N];
   logic [15:0] fdata [N];
   logic        fwe_n [N], foe_n [N], fce_n [N], frst_n [N], done [N];
   logic        stb [N], cyc [N], we [N], tga [N], ack [N];
   logic [1:0]  sel [N];
   logic [18:0] adr [N];
   logic [15:0] dat [N];

   int clk_cnt [N];
   int cecnt   [N];

   bit armed [N];
   int wcnt  [N];
   int wix   [N];
   int w_log [N][RMAX];

   int nrec [N], nrise [N], nce [N], first_frst [N], first_ce [N];
   int done_rise [N], stb_done [N], drop_err [N], rise_hold [N];
   bit prev_stb [N], prev_ce [N], post_acc [N], bad [N];
   logic [18:0] hold_adr [N];
   logic [15:0] hold_dat [N];

   logic [18:0] r_adr  [N][RMAX];
   logic [15:0] r_dat  [N][RMAX];
   logic [21:0] r_fad  [N][RMAX];
   int          r_rise [N][RMAX];
   int          r_acc  [N][RMAX];
   bit          r_bad  [N][RMAX];

   int errs, checks;

   bios_shadow_loader_if wb_a ();
   bios_shadow_loader_if wb_b ();
   bios_shadow_loader_if wb_c ();

   bios_shadow_loader #(.FLASH_BASE(22'h000000), .RAM_BASE(19'h78000), .WORDS(4),
                        .FLASH_WAIT(FW), .RST_CYC(RC)) u_dut_a (
      .wb_clk_i(clk), .wb_rst_n_i(rst_a),
      .flash_addr_(faddr[0]), .flash_data_(fdata[0]), .flash_we_n_(fwe_n[0]),
      .flash_oe_n_(foe_n[0]), .flash_ce_n_(fce_n[0]), .flash_rst_n_(frst_n[0]),
      .wbm(wb_a), .done_o(done[0]));

   bios_shadow_loader #(.FLASH_BASE(22'h000000), .RAM_BASE(19'h78000), .WORDS(1),
                        .FLASH_WAIT(FW), .RST_CYC(RC)) u_dut_b (
      .wb_clk_i(clk), .wb_rst_n_i(rst_bc),
      .flash_addr_(faddr[1]), .flash_data_(fdata[1]), .flash_we_n_(fwe_n[1]),
      .flash_oe_n_(foe_n[1]), .flash_ce_n_(fce_n[1]), .flash_rst_n_(frst_n[1]),
      .wbm(wb_b), .done_o(done[1]));

   bios_shadow_loader #(.FLASH_BASE(22'h3FFFFE), .RAM_BASE(19'h7FFFF), .WORDS(4),
                        .FLASH_WAIT(FW), .RST_CYC(RC)) u_dut_c (
      .wb_clk_i(clk), .wb_rst_n_i(rst_bc),
      .flash_addr_(faddr[2]), .flash_data_(fdata[2]), .flash_we_n_(fwe_n[2]),
      .flash_oe_n_(foe_n[2]), .flash_ce_n_(fce_n[2]), .flash_rst_n_(frst_n[2]),
      .wbm(wb_c), .done_o(done[2]));

   assign rst_n[0] = rst_a;
   assign rst_n[1] = rst_bc;
   assign rst_n[2] = rst_bc;

   assign stb[0] = wb_a.stb;  assign cyc[0] = wb_a.cyc;  assign we[0] = wb_a.we;
   assign tga[0] = wb_a.tga;  assign sel[0] = wb_a.sel;  assign adr[0] = wb_a.adr;
   assign dat[0] = wb_a.dat;  assign wb_a.ack = ack[0];
   assign stb[1] = wb_b.stb;  assign cyc[1] = wb_b.cyc;  assign we[1] = wb_b.we;
   assign tga[1] = wb_b.tga;  assign sel[1] = wb_b.sel;  assign adr[1] = wb_b.adr;
   assign dat[1] = wb_b.dat;  assign wb_b.ack = ack[1];
   assign stb[2] = wb_c.stb;  assign cyc[2] = wb_c.cyc;  assign we[2] = wb_c.we;
   assign tga[2] = wb_c.tga;  assign sel[2] = wb_c.sel;  assign adr[2] = wb_c.adr;
   assign dat[2] = wb_c.dat;  assign wb_c.ack = ack[2];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [21:0] fb_of(input int k);
      return (k == 2) ? 22'h3FFFFE : 22'h000000;
   endfunction
   function automatic logic [18:0] rb_of(input int k);
      return (k == 2) ? 19'h7FFFF : 19'h78000;
   endfunction
   function automatic int w_of(input int k);
      return (k == 1) ? 1 : 4;
   endfunction

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Flash model: data only valid once CE/OE have been low for FW-1 edges
   for (genvar k = 0; k < N; k++) begin : g_flash
      assign fdata[k] = (!fce_n[k] && !foe_n[k] && cecnt[k] >= FW - 1)
                        ? (faddr[k][15:0] ^ 16'hA5A5) : 16'hDEAD;
   end

   always @(posedge clk) begin
      for (int k = 0; k < N; k++) begin
         cecnt[k]   <= fce_n[k] ? 0 : cecnt[k] + 1;
         clk_cnt[k] <= rst_n[k] ? clk_cnt[k] + 1 : 0;
      end
   end

   // Registered-ack slave with random wait states and stray acks when idle
   always @(posedge clk) begin
      int   w;
      logic a_n;
      for (int k = 0; k < N; k++) begin
         a_n = 1'b0;
         if (!rst_n[k]) begin
            armed[k] = 1'b0;
            wix[k]   = 0;
            wcnt[k]  = 0;
         end else if (stb[k] && cyc[k] && !ack[k]) begin
            if (!armed[k]) begin
               w = (k == 0 && wix[k] == 1) ? 3 : int'($urandom_range(0, 3));
               if (wix[k] < RMAX) w_log[k][wix[k]] = w;
               wix[k]++;
               armed[k] = 1'b1;
               if (w == 0) a_n = 1'b1;
               else        wcnt[k] = w;
            end else if (wcnt[k] == 1) begin
               a_n = 1'b1;
            end else begin
               wcnt[k]--;
            end
         end else if (stb[k] && ack[k]) begin
            armed[k] = 1'b0;
         end else if (!stb[k] && spur_en && !(!fce_n[k] && cecnt[k] == FW - 1)) begin
            a_n = ($urandom_range(0, 3) == 0);
         end
         ack[k] <= a_n;
      end
   end

   // Bus and flash monitor, sampled on the falling edge
   always @(negedge clk) begin
      for (int k = 0; k < N; k++) begin
         if (!rst_n[k]) begin
            nrec[k] = 0;  nrise[k] = 0;  nce[k] = 0;
            first_frst[k] = -1;  first_ce[k] = -1;  done_rise[k] = -1;
            stb_done[k] = 0;  drop_err[k] = 0;
            prev_stb[k] = 1'b0;  prev_ce[k] = 1'b1;  post_acc[k] = 1'b0;  bad[k] = 1'b0;
         end else begin
            if (first_frst[k] < 0 && frst_n[k]) first_frst[k] = clk_cnt[k];
            if (!fce_n[k] && prev_ce[k]) begin
               nce[k]++;
               if (first_ce[k] < 0) first_ce[k] = clk_cnt[k];
            end
            if (done[k] && done_rise[k] < 0) done_rise[k] = clk_cnt[k];
            if (done[k] && stb[k]) stb_done[k]++;
            if (post_acc[k] && stb[k]) drop_err[k]++;
            post_acc[k] = 1'b0;
            if (stb[k] && !prev_stb[k]) begin
               nrise[k]++;
               rise_hold[k] = clk_cnt[k];
               hold_adr[k]  = adr[k];
               hold_dat[k]  = dat[k];
               bad[k]       = 1'b0;
            end
            if (stb[k] && (adr[k] != hold_adr[k] || dat[k] != hold_dat[k] || !cyc[k] ||
                           !we[k] || sel[k] != 2'b11 || tga[k] || !fce_n[k] ||
                           !foe_n[k] || !fwe_n[k]))
               bad[k] = 1'b1;
            if (stb[k] && ack[k] && nrec[k] < RMAX) begin
               r_adr[k][nrec[k]]  = adr[k];
               r_dat[k][nrec[k]]  = dat[k];
               r_fad[k][nrec[k]]  = faddr[k];
               r_rise[k][nrec[k]] = rise_hold[k];
               r_acc[k][nrec[k]]  = clk_cnt[k] + 1;
               r_bad[k][nrec[k]]  = bad[k];
               nrec[k]++;
               post_acc[k] = 1'b1;
            end
            prev_stb[k] = stb[k];
            prev_ce[k]  = fce_n[k];
         end
      end
   end

   task automatic wait_done(input int k, input int limit);
      int n;
      n = 0;
      while (!done[k] && n < limit) begin
         @(negedge clk);
         n++;
      end
      check_eq($sformatf("c%0d_done_in_time", k), 64'(done[k]), 64'(1'b1));
   endtask

   // Compare one loader's recorded transfers with the expected image copy
   task automatic check_cfg(input int k);
      int          wn, exp_gap;
      logic [21:0] fa;
      logic [18:0] ra;
      logic [15:0] d;
      wn = w_of(k);
      check_eq($sformatf("c%0d_writes", k), 64'(nrec[k]), 64'(wn));
      check_eq($sformatf("c%0d_stb_rises", k), 64'(nrise[k]), 64'(wn));
      check_eq($sformatf("c%0d_flash_reads", k), 64'(nce[k]), 64'(wn));
      check_eq($sformatf("c%0d_frst_len", k), 64'(first_frst[k]), 64'(RC));
      check_eq($sformatf("c%0d_first_read", k), 64'(first_ce[k]), 64'(2 * RC));
      for (int i = 0; i < wn && i < nrec[k]; i++) begin
         fa = fb_of(k) + 22'(i);
         ra = rb_of(k) + 19'(i);
         d  = fa[15:0] ^ 16'hA5A5;
         check_eq($sformatf("c%0d_w%0d_adr", k, i), 64'(r_adr[k][i]), 64'(ra));
         check_eq($sformatf("c%0d_w%0d_dat", k, i), 64'(r_dat[k][i]), 64'(d));
         check_eq($sformatf("c%0d_w%0d_faddr", k, i), 64'(r_fad[k][i]), 64'(fa));
         check_eq($sformatf("c%0d_w%0d_stable", k, i), 64'(r_bad[k][i]), 64'(1'b0));
         if (i == 0) begin
            exp_gap = 2 * RC + FW;
            check_eq($sformatf("c%0d_w%0d_start", k, i), 64'(r_rise[k][i]), 64'(exp_gap));
         end else begin
            exp_gap = FW;
            check_eq($sformatf("c%0d_w%0d_start", k, i),
                     64'(r_rise[k][i] - r_acc[k][i-1]), 64'(exp_gap));
         end
         check_eq($sformatf("c%0d_w%0d_ack_lat", k, i),
                  64'(r_acc[k][i] - r_rise[k][i]), 64'(2 + w_log[k][i]));
      end
      if (nrec[k] >= wn)
         check_eq($sformatf("c%0d_done_edge", k), 64'(done_rise[k]), 64'(r_acc[k][wn-1]));
      check_eq($sformatf("c%0d_done_sticky", k), 64'(done[k]), 64'(1'b1));
      check_eq($sformatf("c%0d_no_stb_in_done", k), 64'(stb_done[k]), 64'(0));
      check_eq($sformatf("c%0d_stb_drop", k), 64'(drop_err[k]), 64'(0));
   endtask

   initial begin
      int n;
      errs    = 0;
      checks  = 0;
      spur_en = 1'b0;
      rst_a   = 1'b1;
      rst_bc  = 1'b1;
      #1;
      rst_a  = 1'b0;
      rst_bc = 1'b0;
      #1;
      check_eq("rst_flash_ctl", 64'({frst_n[0], fce_n[0], foe_n[0], fwe_n[0]}), 64'(4'b0111));
      check_eq("rst_flash_addr", 64'(faddr[0]), 64'(22'h000000));
      check_eq("rst_wb_ctl", 64'({stb[0], cyc[0], we[0], sel[0]}), 64'(5'b00000));
      check_eq("rst_wb_adr", 64'(adr[0]), 64'(19'h78000));
      check_eq("rst_wb_dat", 64'(dat[0]), 64'(16'h0000));
      check_eq("rst_done", 64'(done[0]), 64'(1'b0));
      check_eq("rst_flash_addr_c", 64'(faddr[2]), 64'(22'h3FFFFE));
      check_eq("rst_wb_adr_c", 64'(adr[2]), 64'(19'h7FFFF));

      repeat (3) @(negedge clk);
      #1;
      spur_en = 1'b1;
      rst_a   = 1'b1;
      rst_bc  = 1'b1;

      // Abort loader A while it is writing word 2
      n = 0;
      while (!(nrec[0] >= 2 && stb[0]) && n < 500) begin
         @(negedge clk);
         n++;
      end
      check_eq("reach_word2_write", 64'(n < 500), 64'(1'b1));
      #2;
      rst_a = 1'b0;
      #1;
      check_eq("abort_wb_ctl", 64'({stb[0], cyc[0], we[0]}), 64'(3'b000));
      check_eq("abort_flash_rst", 64'(frst_n[0]), 64'(1'b0));
      check_eq("abort_flash_addr", 64'(faddr[0]), 64'(22'h000000));
      check_eq("abort_wb_adr", 64'(adr[0]), 64'(19'h78000));
      repeat (3) @(negedge clk);
      #1;
      rst_a = 1'b1;

      wait_done(0, 500);
      wait_done(1, 500);
      wait_done(2, 500);
      repeat (100) @(negedge clk);

      for (int k = 0; k < N; k++) check_cfg(k);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errs);
      $fatal(1, "watchdog");
   end
endmodule
